// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, state and flag types for the alu sequencing front end.
// Also the wide-flag merge used when two 32-bit passes form one 64-bit result.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOT = 3'b100
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIX,
        RESP
    } alu_ctrl_state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= ALU_NOT;
    endfunction

    // Sub carries are "not borrow", so the two passes combine with AND.
    function automatic alu_flags_t wide_flags(
        input logic [2:0]  op,
        input logic        a_msb,
        input logic        b_msb,
        input logic [63:0] r,
        input logic        c_hi,
        input logic        c_fix
    );
        alu_flags_t f;
        f.z = (r == 64'd0);
        f.c = 1'b0;
        f.v = 1'b0;
        if (op == ALU_ADD) begin
            f.c = c_hi | c_fix;
            f.v = (a_msb == b_msb) && (r[63] != a_msb);
        end else if (op == ALU_SUB) begin
            f.c = c_hi & c_fix;
            f.v = (a_msb != b_msb) && (r[63] != a_msb);
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Command and response handshakes between an issuer and alu_ctrl.
// The master side issues commands and consumes responses.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        cmd_wide;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_res;
    logic        rsp_z;
    logic        rsp_c;
    logic        rsp_v;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        input  cmd_ready,
        input  rsp_valid, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        output cmd_ready,
        output rsp_valid, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_ctrl.sv
// Sequences 32-bit alu passes, chaining low/high/fix passes for 64-bit ops,
// and returns registered results over a valid/ready response channel.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_ctrl_if.slave   bus,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_res,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v
);

    alu_ctrl_state_t state;

    logic [2:0]  op_q;
    logic        wide_q;
    logic        err_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        z_lo;
    logic        c_lo;
    logic        v_lo;
    logic        c_hi;
    logic        c_fix;

    logic        need_fix;
    logic [63:0] wide_r;
    alu_flags_t  wide_fl;

    assign bus.cmd_ready = (state == IDLE);

    assign need_fix = ((op_q == ALU_ADD) && c_lo) ||
                      ((op_q == ALU_SUB) && !c_lo);

    assign wide_r  = {res_hi, res_lo};
    assign wide_fl = wide_flags(op_q, a_q[63], b_q[63],
                                wide_r, c_hi, c_fix);

    // ALU drive depends only on state and latched operands.
    always_comb begin
        alu_opA = 32'd0;
        alu_opB = 32'd0;
        alu_sel = 3'b000;
        case (state)
            LO: begin
                alu_opA = a_q[31:0];
                alu_opB = b_q[31:0];
                alu_sel = op_q;
            end
            HI: begin
                alu_opA = a_q[63:32];
                alu_opB = b_q[63:32];
                alu_sel = op_q;
            end
            FIX: begin
                alu_opA = res_hi;
                alu_opB = 32'd1;
                alu_sel = op_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= 3'b000;
            wide_q        <= 1'b0;
            err_q         <= 1'b0;
            a_q           <= 64'd0;
            b_q           <= 64'd0;
            res_lo        <= 32'd0;
            res_hi        <= 32'd0;
            z_lo          <= 1'b0;
            c_lo          <= 1'b0;
            v_lo          <= 1'b0;
            c_hi          <= 1'b0;
            c_fix         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_res   <= 64'd0;
            bus.rsp_z     <= 1'b0;
            bus.rsp_c     <= 1'b0;
            bus.rsp_v     <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q   <= bus.cmd_op;
                        wide_q <= bus.cmd_wide;
                        a_q    <= bus.cmd_a;
                        b_q    <= bus.cmd_b;
                        err_q  <= !op_valid(bus.cmd_op);
                        state  <= op_valid(bus.cmd_op) ? LO : RESP;
                    end
                end
                LO: begin
                    res_lo <= alu_res;
                    z_lo   <= alu_z;
                    c_lo   <= alu_c;
                    v_lo   <= alu_v;
                    state  <= wide_q ? HI : RESP;
                end
                HI: begin
                    res_hi <= alu_res;
                    c_hi   <= alu_c;
                    // Neutral fix carry for the skipped case.
                    c_fix  <= (op_q == ALU_SUB);
                    state  <= need_fix ? FIX : RESP;
                end
                FIX: begin
                    res_hi <= alu_res;
                    c_fix  <= alu_c;
                    state  <= RESP;
                end
                RESP: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err_q;
                        if (err_q) begin
                            bus.rsp_res <= 64'd0;
                            bus.rsp_z   <= 1'b0;
                            bus.rsp_c   <= 1'b0;
                            bus.rsp_v   <= 1'b0;
                        end else if (!wide_q) begin
                            bus.rsp_res <= {32'd0, res_lo};
                            bus.rsp_z   <= z_lo;
                            bus.rsp_c   <= c_lo;
                            bus.rsp_v   <= v_lo;
                        end else begin
                            bus.rsp_res <= wide_r;
                            bus.rsp_z   <= wide_fl.z;
                            bus.rsp_c   <= wide_fl.c;
                            bus.rsp_v   <= wide_fl.v;
                        end
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed plan vectors plus randomized commands
// checked against a 64-bit arithmetic reference model.
module tb_alu_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] alu_opA;
    logic [31:0] alu_opB;
    logic [2:0]  alu_sel;
    logic [31:0] alu_res;
    logic        alu_z;
    logic        alu_c;
    logic        alu_v;

    int asserts = 0;
    int fails   = 0;

    logic [63:0] obs_res;
    logic        obs_z, obs_c, obs_v, obs_err;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        err;
        logic        fix;
        logic [3:0]  lat;
        logic [31:0] hi_pre;
    } exp_t;

    alu_ctrl_if ifc ();

    alu_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifc),
        .alu_opA (alu_opA),
        .alu_opB (alu_opB),
        .alu_sel (alu_sel),
        .alu_res (alu_res),
        .alu_z   (alu_z),
        .alu_c   (alu_c),
        .alu_v   (alu_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external 32-bit alu.
    always_comb begin
        logic [32:0] s;
        logic [31:0] r;
        s = 33'd0;
        r = 32'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_sel)
            3'b000: begin
                s = {1'b0, alu_opA} + {1'b0, alu_opB};
                r = s[31:0];
                alu_c = s[32];
                alu_v = (alu_opA[31] == alu_opB[31]) && (r[31] != alu_opA[31]);
            end
            3'b001: begin
                r = alu_opA - alu_opB;
                alu_c = (alu_opA >= alu_opB);
                alu_v = (alu_opA[31] != alu_opB[31]) && (r[31] != alu_opA[31]);
            end
            3'b010: r = alu_opA & alu_opB;
            3'b011: r = alu_opA | alu_opB;
            3'b100: r = ~alu_opA;
            default: r = 32'd0;
        endcase
        alu_res = r;
        alu_z = (r == 32'd0);
    end

    function automatic exp_t model(input logic [2:0] op, input logic wide,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [32:0] s32;
        logic [64:0] s64;
        logic [31:0] r32;
        logic [63:0] r64;
        e = '0;
        if (op > 3'd4) begin
            e.err = 1'b1;
            e.lat = 4'd1;
            return e;
        end
        if (!wide) begin
            r32 = 32'd0;
            case (op)
                3'd0: begin
                    s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                    r32 = s32[31:0];
                    e.c = s32[32];
                    e.v = (a[31] == b[31]) && (r32[31] != a[31]);
                end
                3'd1: begin
                    r32 = a[31:0] - b[31:0];
                    e.c = (a[31:0] >= b[31:0]);
                    e.v = (a[31] != b[31]) && (r32[31] != a[31]);
                end
                3'd2: r32 = a[31:0] & b[31:0];
                3'd3: r32 = a[31:0] | b[31:0];
                default: r32 = ~a[31:0];
            endcase
            e.res = {32'd0, r32};
            e.z = (r32 == 32'd0);
            e.lat = 4'd2;
        end else begin
            r64 = 64'd0;
            case (op)
                3'd0: begin
                    s64 = {1'b0, a} + {1'b0, b};
                    r64 = s64[63:0];
                    e.c = s64[64];
                    e.v = (a[63] == b[63]) && (r64[63] != a[63]);
                    s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                    e.fix = s32[32];
                    e.hi_pre = a[63:32] + b[63:32];
                end
                3'd1: begin
                    r64 = a - b;
                    e.c = (a >= b);
                    e.v = (a[63] != b[63]) && (r64[63] != a[63]);
                    e.fix = (a[31:0] < b[31:0]);
                    e.hi_pre = a[63:32] - b[63:32];
                end
                3'd2: r64 = a & b;
                3'd3: r64 = a | b;
                default: r64 = ~a;
            endcase
            e.res = r64;
            e.z = (r64 == 64'd0);
            e.lat = e.fix ? 4'd4 : 4'd3;
        end
        return e;
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic wide,
                           input logic [63:0] a, input logic [63:0] b,
                           input int hold);
        exp_t e;
        int cnt;
        logic [63:0] r0;
        logic [3:0]  f0;
        e = model(op, wide, a, b);
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_wide  = wide;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.rsp_ready = (hold == 0);
        asserts++;
        if (ifc.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_ready_idle got %b want 1", ifc.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        // Busy-time noise: must be ignored and must not reach the alu drive.
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 3'b111;
        ifc.cmd_a     = {$urandom, $urandom};
        ifc.cmd_b     = {$urandom, $urandom};
        cnt = 0;
        while (ifc.rsp_valid !== 1'b1 && cnt < 8) begin
            asserts++;
            if (ifc.cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL cmd_ready_busy cyc %0d got %b want 0", cnt, ifc.cmd_ready);
            end
            if (cnt == 0) begin
                asserts++;
                if (e.err && {alu_opA, alu_opB, alu_sel} !== 67'd0) begin
                    fails++;
                    $display("FAIL drive_err got %h/%h/%b want 0/0/000", alu_opA, alu_opB, alu_sel);
                end else if (!e.err && {alu_opA, alu_opB, alu_sel} !== {a[31:0], b[31:0], op}) begin
                    fails++;
                    $display("FAIL drive_lo got %h/%h/%b want %h/%h/%b",
                             alu_opA, alu_opB, alu_sel, a[31:0], b[31:0], op);
                end
            end
            if (cnt == 1 && wide && !e.err) begin
                asserts++;
                if ({alu_opA, alu_opB, alu_sel} !== {a[63:32], b[63:32], op}) begin
                    fails++;
                    $display("FAIL drive_hi got %h/%h/%b want %h/%h/%b",
                             alu_opA, alu_opB, alu_sel, a[63:32], b[63:32], op);
                end
            end
            if (cnt == 2 && e.fix) begin
                asserts++;
                if ({alu_opA, alu_opB, alu_sel} !== {e.hi_pre, 32'd1, op}) begin
                    fails++;
                    $display("FAIL drive_fix got %h/%h/%b want %h/00000001/%b",
                             alu_opA, alu_opB, alu_sel, e.hi_pre, op);
                end
            end
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        ifc.cmd_valid = 1'b0;
        asserts++;
        if (cnt != int'(e.lat)) begin
            fails++;
            $display("FAIL latency op %b wide %b got %0d want %0d", op, wide, cnt, e.lat);
        end
        if (ifc.rsp_valid !== 1'b1) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        obs_res = ifc.rsp_res;
        obs_z   = ifc.rsp_z;
        obs_c   = ifc.rsp_c;
        obs_v   = ifc.rsp_v;
        obs_err = ifc.rsp_err;
        asserts++;
        if (obs_res !== e.res || {obs_z, obs_c, obs_v, obs_err} !== {e.z, e.c, e.v, e.err}) begin
            fails++;
            $display("FAIL result op %b wide %b a %h b %h got %h zcve %b want %h zcve %b",
                     op, wide, a, b, obs_res, {obs_z, obs_c, obs_v, obs_err},
                     e.res, {e.z, e.c, e.v, e.err});
        end
        r0 = obs_res;
        f0 = {obs_z, obs_c, obs_v, obs_err};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            asserts++;
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_res !== r0 || ifc.cmd_ready !== 1'b0 ||
                {ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_err} !== f0) begin
                fails++;
                $display("FAIL hold cyc %0d got v%b rdy%b %h %b want v1 rdy0 %h %b", i,
                         ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_res,
                         {ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_err}, r0, f0);
            end
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        asserts++;
        if (ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL handshake got valid %b ready %b want 0 1", ifc.rsp_valid, ifc.cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 3'b000;
        ifc.cmd_wide  = 1'b0;
        ifc.cmd_a     = 64'd0;
        ifc.cmd_b     = 64'd0;
        ifc.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b1 || ifc.rsp_res !== 64'd0 ||
            {ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_err} !== 4'd0) begin
            fails++;
            $display("FAIL reset_rsp got v%b rdy%b %h %b want v0 rdy1 0 0000", ifc.rsp_valid,
                     ifc.cmd_ready, ifc.rsp_res, {ifc.rsp_z, ifc.rsp_c, ifc.rsp_v, ifc.rsp_err});
        end
        asserts++;
        if ({alu_opA, alu_opB, alu_sel} !== 67'd0) begin
            fails++;
            $display("FAIL reset_drive got %h/%h/%b want 0/0/000", alu_opA, alu_opB, alu_sel);
        end
    endtask

    task automatic test_narrow();
        run_cmd(3'b000, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 0);
        asserts++;
        if (obs_res !== 64'h0000_0000_8000_0000 || {obs_z, obs_c, obs_v} !== 3'b001) begin
            fails++;
            $display("FAIL narrow_add got %h zcv %b want 0000000080000000 001",
                     obs_res, {obs_z, obs_c, obs_v});
        end
        run_cmd(3'b001, 1'b0, 64'd5, 64'd5, 0);
        asserts++;
        if (obs_res !== 64'd0 || {obs_z, obs_c, obs_v} !== 3'b110) begin
            fails++;
            $display("FAIL narrow_sub got %h zcv %b want 0 110", obs_res, {obs_z, obs_c, obs_v});
        end
        run_cmd(3'b100, 1'b0, 64'hDEAD_BEEF_0000_FFFF, 64'd0, 0);
        asserts++;
        if (obs_res !== 64'h0000_0000_FFFF_0000) begin
            fails++;
            $display("FAIL narrow_not got %h want 00000000ffff0000", obs_res);
        end
    endtask

    task automatic test_wide();
        run_cmd(3'b000, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        asserts++;
        if (obs_res !== 64'h0000_0001_0000_0000 || {obs_z, obs_c, obs_v} !== 3'b000) begin
            fails++;
            $display("FAIL wide_add got %h zcv %b want 0000000100000000 000",
                     obs_res, {obs_z, obs_c, obs_v});
        end
        run_cmd(3'b001, 1'b1, 64'd0, 64'd1, 0);
        asserts++;
        if (obs_res !== 64'hFFFF_FFFF_FFFF_FFFF || {obs_z, obs_c, obs_v} !== 3'b000) begin
            fails++;
            $display("FAIL wide_sub0 got %h zcv %b want ffffffffffffffff 000",
                     obs_res, {obs_z, obs_c, obs_v});
        end
        run_cmd(3'b001, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 0);
        asserts++;
        if (obs_res !== 64'h7FFF_FFFF_FFFF_FFFF || {obs_c, obs_v} !== 2'b11) begin
            fails++;
            $display("FAIL wide_sub_ovf got %h cv %b want 7fffffffffffffff 11",
                     obs_res, {obs_c, obs_v});
        end
        run_cmd(3'b000, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 0);
        asserts++;
        if (obs_res !== 64'd0 || {obs_z, obs_c} !== 2'b11) begin
            fails++;
            $display("FAIL wide_add_wrap got %h zc %b want 0 11", obs_res, {obs_z, obs_c});
        end
    endtask

    task automatic test_invalid_hold();
        run_cmd(3'b101, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1, 3);
        asserts++;
        if (obs_err !== 1'b1 || obs_res !== 64'd0) begin
            fails++;
            $display("FAIL invalid got err %b res %h want 1 0", obs_err, obs_res);
        end
        run_cmd(3'b000, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 2);
    endtask

    task automatic test_reset_in_hi();
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 3'b000;
        ifc.cmd_wide  = 1'b1;
        ifc.cmd_a     = 64'hAAAA_0000_FFFF_FFFF;
        ifc.cmd_b     = 64'h1111_0000_0000_0001;
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        asserts++;
        if (alu_opA !== 32'hAAAA_0000) begin
            fails++;
            $display("FAIL hi_entry got %h want aaaa0000", alu_opA);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (ifc.rsp_valid !== 1'b0 || {alu_opA, alu_opB, alu_sel} !== 67'd0 ||
            ifc.cmd_ready !== 1'b1 || ifc.rsp_res !== 64'd0) begin
            fails++;
            $display("FAIL reset_hi got v%b %h/%h/%b rdy%b res %h want v0 0/0/000 rdy1 0",
                     ifc.rsp_valid, alu_opA, alu_opB, alu_sel, ifc.cmd_ready, ifc.rsp_res);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            asserts++;
            if (ifc.rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_hi_quiet cyc %0d got valid %b want 0", i, ifc.rsp_valid);
            end
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) op = 3'($urandom_range(5, 7));
            else op = 3'($urandom_range(0, 4));
            run_cmd(op, 1'($urandom_range(0, 1)), {pick32(), pick32()},
                    {pick32(), pick32()}, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_narrow();
        test_wide();
        test_invalid_hold();
        test_reset_in_hi();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
